// File: rtl/branch_predictor.sv
// Conditional-branch predictor: static / bimodal / gshare over a saturating-counter table,
// with speculative + architectural global history. Optional return stack under RAS_EN.
module branch_predictor #(
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int MODE      = 1,
    parameter int GHR_BITS  = 6,
    parameter int RAS_DEPTH = 4,
    localparam int IDX      = $clog2(ENTRIES)
) (
    input  logic                clk_core,
    input  logic                reset_n,
    input  logic                de_lookup,
    input  logic                de_stall,
    input  logic                kill,
    input  logic [31:2]         de_pc,
    input  logic                de_imm_sign,
    output logic                bp_taken,
    output logic [IDX-1:0]      bp_index,
    output logic [GHR_BITS-1:0] bp_ghr,
    output logic                bp_ready,
    input  logic                ex_update,
    input  logic [IDX-1:0]      ex_index,
    input  logic [GHR_BITS-1:0] ex_ghr,
    input  logic                ex_taken,
    input  logic                ex_mispredict,
    input  logic                de_call,
    input  logic                de_ret,
    input  logic [31:2]         de_link_pc,
    output logic                ras_valid,
    output logic [31:2]         ras_target
);

    // state | meaning
    // INIT  | sweeping the table to weakly-not-taken, one entry per cycle
    // RUN   | predicting and training
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    state_t              state, state_nxt;
    logic [IDX-1:0]      clr_idx;
    logic                init_we;
    logic [CTR_BITS-1:0] ctr [ENTRIES];
    logic [CTR_BITS-1:0] upd_ctr, upd_nxt;
    logic [GHR_BITS-1:0] spec_ghr, arch_ghr, arch_nxt;
    logic [GHR_BITS:0]   ex_shift, spec_shift;
    logic [IDX-1:0]      lk_idx;
    logic                acc, upd;

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && clr_idx == IDX'(ENTRIES - 1)) state_nxt = RUN;
    end

    always_comb begin
        bp_ready = (state == RUN);
        init_we  = (state == INIT);
    end

    assign acc = de_lookup & ~de_stall & ~kill;
    assign upd = ex_update & bp_ready;

    assign lk_idx   = (MODE == 2) ? (de_pc[IDX+1:2] ^ IDX'(spec_ghr)) : de_pc[IDX+1:2];
    assign bp_index = lk_idx;
    assign bp_taken = (MODE == 0 || !bp_ready) ? de_imm_sign : ctr[lk_idx][CTR_BITS-1];
    assign bp_ghr   = spec_ghr;

    assign upd_ctr = ctr[ex_index];
    always_comb begin
        upd_nxt = upd_ctr;
        if (ex_taken) begin
            if (upd_ctr != CTR_MAX) upd_nxt = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_nxt = upd_ctr - 1'b1;
        end
    end

    // Table is not cleared by reset itself; INIT rewrites every entry after reset.
    always_ff @(posedge clk_core) begin
        if (reset_n) begin
            if (init_we)  ctr[clr_idx]  <= CTR_INIT;
            else if (upd) ctr[ex_index] <= upd_nxt;
        end
    end

    assign ex_shift   = {ex_ghr, ex_taken};
    assign spec_shift = {spec_ghr, bp_taken};
    assign arch_nxt   = upd ? ex_shift[GHR_BITS-1:0] : arch_ghr;

    // Repair copies the post-update architectural history and overrides a same-cycle lookup.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            spec_ghr <= '0;
            arch_ghr <= '0;
        end else if (MODE != 0) begin
            arch_ghr <= arch_nxt;
            if ((upd && ex_mispredict) || kill) spec_ghr <= arch_nxt;
            else if (acc)                       spec_ghr <= spec_shift[GHR_BITS-1:0];
        end
    end

`ifdef RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [31:2]   stack [RAS_DEPTH];
    logic [PW-1:0] ras_ptr;
    logic [CW-1:0] ras_cnt;
    logic          push, pop;

    assign push = de_call & ~de_stall & ~kill;
    assign pop  = de_ret & ~de_stall & ~kill;

    // Full stack wraps onto the oldest entry; the count just pins at depth.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) stack[i] <= '0;
        end else if (push && pop) begin
            stack[ras_ptr] <= de_link_pc;
        end else if (push) begin
            stack[ras_ptr + 1'b1] <= de_link_pc;
            ras_ptr <= ras_ptr + 1'b1;
            if (ras_cnt != CW'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
        end else if (pop && ras_cnt != '0) begin
            ras_ptr <= ras_ptr - 1'b1;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end

    assign ras_valid  = (ras_cnt != '0);
    assign ras_target = stack[ras_ptr];

    logic unused_pc;
    assign unused_pc = ^de_pc[31:IDX+2];
`else
    assign ras_valid  = 1'b0;
    assign ras_target = '0;

    logic unused_ras;
    assign unused_ras = ^{de_call, de_ret, de_link_pc, de_pc[31:IDX+2]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal and a gshare instance driven from shared stimulus.
module tb_branch_predictor;
    localparam int IDX = 6;
    localparam int GB  = 6;

    logic          clk_core = 1'b0;
    logic          reset_n;
    logic          de_lookup, de_stall, kill, de_imm_sign;
    logic [31:2]   de_pc, de_link_pc;
    logic          ex_update, ex_taken, ex_mispredict, de_call, de_ret;
    logic [IDX-1:0] ex_index;
    logic [GB-1:0]  ex_ghr;

    logic          bim_taken, bim_ready, bim_rv, gsh_taken, gsh_ready, gsh_rv;
    logic [IDX-1:0] bim_idx, gsh_idx;
    logic [GB-1:0]  bim_ghr, gsh_ghr;
    logic [31:2]    bim_rt, gsh_rt;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk_core = ~clk_core;

    branch_predictor #(.MODE(1)) u_bim (
        .clk_core(clk_core), .reset_n(reset_n), .de_lookup(de_lookup), .de_stall(de_stall),
        .kill(kill), .de_pc(de_pc), .de_imm_sign(de_imm_sign), .bp_taken(bim_taken),
        .bp_index(bim_idx), .bp_ghr(bim_ghr), .bp_ready(bim_ready), .ex_update(ex_update),
        .ex_index(ex_index), .ex_ghr(ex_ghr), .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
        .de_call(de_call), .de_ret(de_ret), .de_link_pc(de_link_pc),
        .ras_valid(bim_rv), .ras_target(bim_rt));

    branch_predictor #(.MODE(2)) u_gsh (
        .clk_core(clk_core), .reset_n(reset_n), .de_lookup(de_lookup), .de_stall(de_stall),
        .kill(kill), .de_pc(de_pc), .de_imm_sign(de_imm_sign), .bp_taken(gsh_taken),
        .bp_index(gsh_idx), .bp_ghr(gsh_ghr), .bp_ready(gsh_ready), .ex_update(ex_update),
        .ex_index(ex_index), .ex_ghr(ex_ghr), .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
        .de_call(de_call), .de_ret(de_ret), .de_link_pc(de_link_pc),
        .ras_valid(gsh_rv), .ras_target(gsh_rt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic upd(input int idx, input logic tk);
        ex_update = 1'b1; ex_index = IDX'(idx); ex_taken = tk; ex_mispredict = 1'b0;
        tick();
        ex_update = 1'b0;
        #1;
    endtask

    task automatic count_init(input string tag);
        n = 0;
        while (!bim_ready && n < 200) begin
            if (n == 3) begin de_imm_sign = 1'b1; #1; chk("init_static1", 32'(bim_taken), 32'd1); end
            if (n == 5) begin de_imm_sign = 1'b0; #1; chk("init_static0", 32'(bim_taken), 32'd0); end
            tick();
            n++;
        end
        chk(tag, n, 64);
    endtask

    initial begin
        reset_n = 1'b0; de_lookup = 0; de_stall = 0; kill = 0; de_imm_sign = 0;
        de_pc = '0; de_link_pc = '0; ex_update = 0; ex_taken = 0; ex_mispredict = 0;
        ex_index = '0; ex_ghr = '0; de_call = 0; de_ret = 0;

        tick();
        chk("rst_ready", 32'(bim_ready), 32'd0);
        chk("rst_ghr", 32'(gsh_ghr), 32'd0);
        tick();
        reset_n = 1'b1;
        count_init("init_len");

        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        chk("midrst_ready", 32'(bim_ready), 32'd0);
        reset_n = 1'b1;
        count_init("init_len2");

        // gshare history: predictions during INIT follow the immediate sign
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        de_lookup = 1'b1;
        de_imm_sign = 1'b1; tick();
        de_imm_sign = 1'b0; tick();
        de_imm_sign = 1'b1; tick();
        de_lookup = 1'b0; de_imm_sign = 1'b0; #1;
        chk("ghr_101", 32'(gsh_ghr), 32'h05);
        de_lookup = 1'b1; de_stall = 1'b1; tick();
        de_lookup = 1'b0; de_stall = 1'b0; #1;
        chk("ghr_stall", 32'(gsh_ghr), 32'h05);
        n = 0;
        while (!gsh_ready && n < 200) begin tick(); n++; end
        chk("gsh_ready", 32'(gsh_ready), 32'd1);
        de_lookup = 1'b1; de_pc = 30'h7; #1;
        chk("gsh_pred0", 32'(gsh_taken), 32'd0);
        tick();
        de_lookup = 1'b0; #1;
        chk("ghr_shift", 32'(gsh_ghr), 32'h0A);
        ex_update = 1'b1; ex_mispredict = 1'b1; ex_index = 6'd60; ex_ghr = 6'b000010; ex_taken = 1'b1;
        tick();
        ex_update = 1'b0; ex_mispredict = 1'b0; #1;
        chk("ghr_repair", 32'(gsh_ghr), 32'h05);
        de_lookup = 1'b1;
        ex_update = 1'b1; ex_mispredict = 1'b1; ex_index = 6'd60; ex_ghr = 6'b000011; ex_taken = 1'b0;
        tick();
        ex_update = 1'b0; ex_mispredict = 1'b0; #1;
        chk("ghr_repair_wins", 32'(gsh_ghr), 32'h06);
        chk("gsh_index", 32'(gsh_idx), 32'h01);
        de_lookup = 1'b0;

        // bimodal training, index 0
        de_lookup = 1'b1; de_pc = 30'(32'h100 >> 2); #1;
        chk("bim_idx0", 32'(bim_idx), 32'd0);
        chk("bim_init_nt", 32'(bim_taken), 32'd0);
        upd(0, 1'b1);
        chk("bim_t1", 32'(bim_taken), 32'd1);
        upd(0, 1'b0);
        chk("bim_nt1", 32'(bim_taken), 32'd0);

        // saturation, index 3
        de_pc = 30'h3;
        for (int i = 0; i < 5; i++) upd(3, 1'b1);
        chk("sat_hi", 32'(bim_taken), 32'd1);
        upd(3, 1'b0);
        chk("sat_10", 32'(bim_taken), 32'd1);
        upd(3, 1'b0);
        chk("sat_01", 32'(bim_taken), 32'd0);
        upd(3, 1'b0);
        upd(3, 1'b0);
        upd(3, 1'b1);
        chk("sat_lo", 32'(bim_taken), 32'd0);
        upd(3, 1'b1);
        chk("sat_lo_10", 32'(bim_taken), 32'd1);

        // same-cycle update and lookup, index 5
        de_pc = 30'h5;
        ex_update = 1'b1; ex_index = 6'd5; ex_taken = 1'b1; #1;
        chk("bypass_none", 32'(bim_taken), 32'd0);
        tick();
        ex_update = 1'b0; #1;
        chk("bypass_next", 32'(bim_taken), 32'd1);
        de_lookup = 1'b0;

`ifdef RAS_EN
        de_call = 1'b1;
        de_link_pc = 30'(32'h1004 >> 2); tick();
        de_link_pc = 30'(32'h2008 >> 2); tick();
        de_call = 1'b0; #1;
        chk("ras_top_b", 32'(bim_rt), 32'h802);
        de_ret = 1'b1; tick(); de_ret = 1'b0; #1;
        chk("ras_top_a", 32'(bim_rt), 32'h401);
        chk("ras_valid_a", 32'(bim_rv), 32'd1);
        de_ret = 1'b1; tick(); de_ret = 1'b0; #1;
        chk("ras_empty", 32'(bim_rv), 32'd0);
        de_call = 1'b1;
        for (int i = 1; i <= 5; i++) begin de_link_pc = 30'(i); tick(); end
        de_call = 1'b0; #1;
        for (int i = 5; i >= 2; i--) begin
            chk("ras_pop_valid", 32'(bim_rv), 32'd1);
            chk("ras_pop_target", 32'(bim_rt), 32'(i));
            de_ret = 1'b1; tick(); de_ret = 1'b0; #1;
        end
        chk("ras_oldest_lost", 32'(bim_rv), 32'd0);
`else
        de_call = 1'b1; de_link_pc = 30'h123; tick();
        de_call = 1'b0; #1;
        chk("noras_valid", 32'(bim_rv), 32'd0);
        chk("noras_target", 32'(bim_rt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised dynamic conditional-branch predictor for the decode stage. It replaces the fixed backward-taken/forward-not-taken rule (immediate sign bit) with a selectable static, bimodal or gshare scheme built on a table of saturating counters. Decode looks up a prediction in the same cycle. Execute trains the table and repairs global history on resolution.

Parameters:
ENTRIES, 64, number of counters; power of 2, >= 4; IDX = $clog2(ENTRIES)
CTR_BITS, 2, saturating counter width, >= 1
MODE, 1, 0 = static sign-bit, 1 = bimodal (PC index), 2 = gshare (PC xor history)
GHR_BITS, 6, global history length, 1..IDX
RAS_DEPTH, 4, return stack entries, power of 2 (used only with RAS_EN)

Ports:
clk_core  in  1  core clock; all state updates on rising edge
reset_n  in  1  reset; one clock; synchronous, active-low
de_lookup  in  1  decode holds a valid conditional branch
de_stall  in  1  decode stalled; lookup not accepted this cycle
kill  in  1  pipeline flush (CSR kill or taken branch in execute)
de_pc  in  30  branch PC [31:2]
de_imm_sign  in  1  branch immediate bit 31 (static fallback)
bp_taken  out  1  predicted taken, combinational from current state
bp_index  out  IDX  table index used; carried to execute
bp_ghr  out  GHR_BITS  speculative history snapshot before this branch
bp_ready  out  1  table initialised
ex_update  in  1  execute resolved a conditional branch
ex_index  in  IDX  bp_index carried with it
ex_ghr  in  GHR_BITS  bp_ghr carried with it
ex_taken  in  1  actual outcome
ex_mispredict  in  1  prediction was wrong (qualified by ex_update)
de_call  in  1  accepted JAL/JALR with rd = x1/x5
de_ret  in  1  accepted JALR rs1 = x1/x5, rd = x0
de_link_pc  in  30  return address [31:2] to push
ras_valid  out  1  ras_target meaningful
ras_target  out  30  predicted return address [31:2]

Behaviour:
- Accepted lookup: acc = de_lookup & ~de_stall & ~kill.
- FSM states are INIT and RUN. reset_n low forces INIT with clr_idx = 0, including mid-operation.
- INIT writes counter[clr_idx] = 2^(CTR_BITS-1)-1 (weakly not-taken) and increments clr_idx each cycle. It moves to RUN after writing entry ENTRIES-1, so INIT lasts exactly ENTRIES cycles.
- ex_update is ignored while in INIT.
- bp_ready = (state == RUN). Its reset value is 0.
- Index:
  - MODE 1: de_pc[IDX+1:2].
  - MODE 2: de_pc[IDX+1:2] xor zero-extended spec_ghr.
  - MODE 0: index and table unused; bp_index = de_pc[IDX+1:2].
- bp_taken:
  - MODE 0, or state INIT: de_imm_sign.
  - Otherwise: MSB of counter[index].
- Table read is asynchronous on current contents; there is no write-to-read bypass. A same-cycle update to the same index is seen on the next cycle.
- Training: on ex_update in RUN, counter[ex_index] saturating-increments if ex_taken, else saturating-decrements. It clamps at 0 and at 2^CTR_BITS-1. Write latency is 1 cycle.
- History registers: spec_ghr and arch_ghr, both reset to 0.
  - bp_ghr = spec_ghr.
  - On acc: spec_ghr <= {spec_ghr[GHR_BITS-2:0], bp_taken}.
  - On ex_update: arch_ghr <= {ex_ghr[GHR_BITS-2:0], ex_taken}.
  - On ex_update & ex_mispredict, or on kill: spec_ghr <= the next value of arch_ghr (including any same-cycle update).
  - Repair has priority over acc.
- MODE 0 keeps both history registers at 0.

Optional Feature:
RAS_EN.
- Defined: return address stack, RAS_DEPTH entries, circular, with top pointer and occupancy count (both reset 0).
  - de_call & ~de_stall & ~kill pushes de_link_pc. When full, the push overwrites the oldest entry and count stays at RAS_DEPTH.
  - de_ret under the same qualification pops, with count saturating at 0.
  - Call and ret in the same cycle replace the top entry; count is unchanged.
  - ras_valid = (count != 0). ras_target = top entry.
  - kill does not repair the stack.
- Undefined: stack not built; ras_valid = 0 and ras_target = 0 always; de_call, de_ret and de_link_pc are ignored.

Test Plan:
1. Reset: reset_n low 2 cycles then high, ENTRIES=64 -> bp_ready 0 for exactly 64 cycles, then 1. During INIT, de_imm_sign=1 gives bp_taken=1 and de_imm_sign=0 gives bp_taken=0. Assert reset_n mid-run -> bp_ready drops and the 64-cycle INIT restarts.
2. Bimodal training, MODE=1, pc 0x100 (index 0):
   - Lookup -> bp_taken 0 (counter 01).
   - One ex_update taken at index 0 -> next-cycle lookup bp_taken 1 (10).
   - One not-taken -> bp_taken 0.
3. Saturation, MODE=1: 5 taken updates to index 3 -> counter 11. One not-taken -> 10, bp_taken still 1. Two more not-taken -> 00; a further not-taken stays 00.
4. Same-cycle update/lookup: update taken to index 5 while looking up index 5 at counter 01 -> bp_taken 0 this cycle, 1 next cycle.
5. gshare history, MODE=2:
   - Accepted lookups predicting 1,0,1 -> bp_ghr = 6'b000101.
   - Lookup with de_stall=1 -> bp_ghr unchanged.
   - ex_update, ex_mispredict=1, ex_ghr=6'b000010, ex_taken=1 -> next cycle bp_ghr = 6'b000101.
   - Same cycle as an accepted lookup -> repair wins.
6. RAS_EN, RAS_DEPTH=4:
   - Push 0x1004>>2 then 0x2008>>2; ret -> ras_target 0x2008>>2.
   - Ret -> ras_target 0x1004>>2.
   - Ret -> ras_valid 0.
   - Five pushes -> count stays 4 and the oldest entry is lost.
